// File: rtl/conway_pkg.sv
// Shared types and constants for the Conway board-engine serial host.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package conway_pkg;

  localparam int BOARD_CELLS = 64;

  // Mode presented to the board engine.
  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHIFT = 2'b01,
    MODE_GEN   = 2'b10
  } ser_mode_e;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_STEP = 2'b01,
    OP_READ = 2'b10,
    OP_RSVD = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STEP,
    ST_READ,
    ST_RESP
  } state_e;

  // Number of live cells in a board image (0..64 fits in 7 bits).
  function automatic logic [6:0] popcount64(input logic [BOARD_CELLS-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < BOARD_CELLS; i++) begin
      c = c + 7'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/conway_serial_shifter.sv
// 64-bit shift register: parallel load, or shift left with serial input at bit 0.
// Latency: one cycle from load/shift request to updated contents; shift_out is bit 63.
// Backpressure: none; load has priority over shift.
// Ports: clk, reset (sync, active-high); load_en/load_dat parallel load;
//        shift_en/shift_in serial shift; shift_out = MSB; nxt_dat = next-cycle contents.
module conway_serial_shifter
  import conway_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_en,
  input  logic [BOARD_CELLS-1:0] load_dat,
  input  logic                   shift_en,
  input  logic                   shift_in,
  output logic                   shift_out,
  output logic [BOARD_CELLS-1:0] nxt_dat
);

  logic [BOARD_CELLS-1:0] sr_q;
  logic [BOARD_CELLS-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_en) begin
      sr_d = load_dat;
    end else if (shift_en) begin
      sr_d = {sr_q[BOARD_CELLS-2:0], shift_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign shift_out = sr_q[BOARD_CELLS-1];
  assign nxt_dat   = sr_d;

endmodule

// File: rtl/conway_serial_host.sv
// Command host that loads, steps and reads back a serial 8x8 Conway board engine.
// Latency: LOAD/READ 64 cycles, STEP cmd_count cycles, then one RESP cycle; +2 cycles min spacing.
// Backpressure: cmd_ready only in IDLE; responses are single-cycle pulses with no backpressure.
// Ports: clk, reset (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_board/cmd_count command;
//        ser_out/ser_mode/ser_in engine link; rsp_valid/rsp_err/rsp_board response.
// Option: define CONWAY_HOST_POPCOUNT_EN to add rsp_popcount (live cells in rsp_board).
module conway_serial_host
  import conway_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [BOARD_CELLS-1:0] cmd_board,
  input  logic [7:0]             cmd_count,
  output logic                   ser_out,
  output logic [1:0]             ser_mode,
  input  logic                   ser_in,
  output logic                   rsp_valid,
  output logic                   rsp_err,
`ifdef CONWAY_HOST_POPCOUNT_EN
  output logic [6:0]             rsp_popcount,
`endif
  output logic [BOARD_CELLS-1:0] rsp_board
);

  localparam logic [6:0] LAST_CELL = 7'(BOARD_CELLS - 1);

  state_e                 state_q, state_d;
  logic [6:0]             shift_cnt_q, shift_cnt_d;
  logic [7:0]             step_cnt_q, step_cnt_d;
  logic                   err_q, err_d;
  logic [BOARD_CELLS-1:0] rsp_board_q, rsp_board_d;

  logic                   accept;
  logic                   sh_load, sh_shift, sh_in, sh_out;
  logic [BOARD_CELLS-1:0] sh_nxt;
  ser_mode_e              mode;

  assign cmd_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;

  conway_serial_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load_en   (sh_load),
    .load_dat  (cmd_board),
    .shift_en  (sh_shift),
    .shift_in  (sh_in),
    .shift_out (sh_out),
    .nxt_dat   (sh_nxt)
  );

  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    step_cnt_d  = step_cnt_q;
    err_d       = err_q;
    mode        = MODE_HOLD;
    ser_out     = 1'b0;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    sh_in       = 1'b0;
    rsp_valid   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          err_d       = 1'b0;
          shift_cnt_d = '0;
          // The step counter doubles as the latched generation count.
          step_cnt_d  = cmd_count;
          case (cmd_op)
            OP_LOAD: begin
              sh_load = 1'b1;
              state_d = ST_LOAD;
            end
            OP_READ: state_d = ST_READ;
            OP_STEP: state_d = (cmd_count == 8'd0) ? ST_RESP : ST_STEP;
            default: begin
              err_d   = 1'b1;
              state_d = ST_RESP;
            end
          endcase
        end
      end

      ST_LOAD: begin
        mode     = MODE_SHIFT;
        ser_out  = sh_out;
        sh_shift = 1'b1;
        if (shift_cnt_q == LAST_CELL) begin
          shift_cnt_d = '0;
          state_d     = ST_RESP;
        end else begin
          shift_cnt_d = shift_cnt_q + 7'd1;
        end
      end

      ST_READ: begin
        // Recirculate so the engine ends up with its original image,
        // while capturing each cell into the local shifter.
        mode     = MODE_SHIFT;
        ser_out  = ser_in;
        sh_shift = 1'b1;
        sh_in    = ser_in;
        if (shift_cnt_q == LAST_CELL) begin
          shift_cnt_d = '0;
          state_d     = ST_RESP;
        end else begin
          shift_cnt_d = shift_cnt_q + 7'd1;
        end
      end

      ST_STEP: begin
        // Entered only with a non-zero count, so counting down to 1 never wraps.
        mode = MODE_GEN;
        if (step_cnt_q == 8'd1) begin
          step_cnt_d = '0;
          state_d    = ST_RESP;
        end else begin
          step_cnt_d = step_cnt_q - 8'd1;
        end
      end

      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // The whole image is published at once, on the final READ shift.
  assign rsp_board_d = (state_q == ST_READ && shift_cnt_q == LAST_CELL) ? sh_nxt : rsp_board_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_cnt_q <= '0;
      step_cnt_q  <= '0;
      err_q       <= 1'b0;
      rsp_board_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      step_cnt_q  <= step_cnt_d;
      err_q       <= err_d;
      rsp_board_q <= rsp_board_d;
    end
  end

  assign ser_mode  = mode;
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_board = rsp_board_q;

`ifdef CONWAY_HOST_POPCOUNT_EN
  logic [6:0] popcount_q, popcount_d;

  assign popcount_d = popcount64(rsp_board_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      popcount_q <= '0;
    end else begin
      popcount_q <= popcount_d;
    end
  end

  assign rsp_popcount = popcount_q;
`endif

endmodule
